// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave front-end of the SPI-to-RAM bridge.
package spi_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CMD_W  = DEF_DATA_W + 2;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_CHK_CMD_ENC   = 3'd1;
  localparam logic [2:0] ST_WRITE_ENC     = 3'd2;
  localparam logic [2:0] ST_READ_ADD_ENC  = 3'd3;
  localparam logic [2:0] ST_READ_DATA_ENC = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = ST_IDLE_ENC,
    StChkCmd   = ST_CHK_CMD_ENC,
    StWrite    = ST_WRITE_ENC,
    StReadAdd  = ST_READ_ADD_ENC,
    StReadData = ST_READ_DATA_ENC
  } spi_state_e;

endpackage

// File: rtl/spi_piso_shift.sv
// Parallel-load / serial-out shifter for MISO: drives the loaded word MSB first, then idles at 0.
module spi_piso_shift #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_SPI_clk,
  input  logic              i_SPI_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_last
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bit_q;

  // cnt_q counts bits still on the wire, including the one currently driven.
  always_ff @(posedge i_SPI_clk or negedge i_SPI_rst_n) begin
    if (!i_SPI_rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      bit_q <= 1'b0;
    end else if (i_clear) begin
      cnt_q <= '0;
      bit_q <= 1'b0;
    end else if (i_load) begin
      sr_q  <= {i_data[DATA_W-2:0], 1'b0};
      bit_q <= i_data[DATA_W-1];
      cnt_q <= CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      if (cnt_q == CNT_W'(1)) begin
        bit_q <= 1'b0;
      end else begin
        bit_q <= sr_q[DATA_W-1];
        sr_q  <= {sr_q[DATA_W-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign o_bit  = bit_q;
  assign o_last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: deserialises {op, byte} frames for the RAM and serialises read data on MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CMD_W  = DATA_W + 2
) (
  input  logic              i_SPI_clk,
  input  logic              i_SPI_rst_n,
  input  logic              i_SPI_ss_n,
  input  logic              i_SPI_mosi,
  output logic              o_SPI_miso,
  output logic [CMD_W-1:0]  o_SPI_rx_data,
  output logic              o_SPI_rx_valid,
  input  logic [DATA_W-1:0] i_SPI_tx_data,
  input  logic              i_SPI_tx_valid
);

  localparam int unsigned CNT_W = $clog2(CMD_W);

  spi_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CMD_W-2:0] shreg_q;
  logic [CMD_W-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             rd_addr_seen_q;
  logic             wait_tx_q;
  logic             piso_load;
  logic             piso_last;

  // Accept RAM data only after the strobe cycle, while still selected.
  assign piso_load = (state_q == StReadData) && wait_tx_q && !rx_valid_q &&
                     i_SPI_tx_valid && !i_SPI_ss_n;

  always_ff @(posedge i_SPI_clk or negedge i_SPI_rst_n) begin
    if (!i_SPI_rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      shreg_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      wait_tx_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (i_SPI_ss_n) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        wait_tx_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StChkCmd;
          StChkCmd: begin
            shreg_q <= {shreg_q[CMD_W-3:0], i_SPI_mosi};
            cnt_q   <= CNT_W'(1);
            if (i_SPI_mosi != OP_RD_ADDR[1]) state_q <= StWrite;
            else if (rd_addr_seen_q)         state_q <= StReadData;
            else                             state_q <= StReadAdd;
          end
          StWrite, StReadAdd, StReadData: begin
            if (cnt_q < CNT_W'(CMD_W - 1)) begin
              shreg_q <= {shreg_q[CMD_W-3:0], i_SPI_mosi};
              cnt_q   <= cnt_q + CNT_W'(1);
            end else if (cnt_q == CNT_W'(CMD_W - 1)) begin
              // Saturate the counter so the held frame never strobes again.
              rx_data_q  <= {shreg_q, i_SPI_mosi};
              rx_valid_q <= 1'b1;
              cnt_q      <= CNT_W'(CMD_W);
              if (state_q == StReadAdd)  rd_addr_seen_q <= 1'b1;
              if (state_q == StReadData) wait_tx_q      <= 1'b1;
            end
            if (piso_load) wait_tx_q <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
      if (piso_last) rd_addr_seen_q <= 1'b0;
    end
  end

  spi_piso_shift #(
    .DATA_W (DATA_W)
  ) u_piso (
    .i_SPI_clk   (i_SPI_clk),
    .i_SPI_rst_n (i_SPI_rst_n),
    .i_clear     (i_SPI_ss_n),
    .i_load      (piso_load),
    .i_data      (i_SPI_tx_data),
    .o_bit       (o_SPI_miso),
    .o_last      (piso_last)
  );

  assign o_SPI_rx_data  = rx_data_q;
  assign o_SPI_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frame table, reset corner cases and randomized frames vs a model.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int errors = 0;
  int checks = 0;
  bit model_seen;

  always #5 clk = ~clk;

  spi_slave dut (
    .i_SPI_clk      (clk),
    .i_SPI_rst_n    (rst_n),
    .i_SPI_ss_n     (ss_n),
    .i_SPI_mosi     (mosi),
    .o_SPI_miso     (miso),
    .o_SPI_rx_data  (rx_data),
    .o_SPI_rx_valid (rx_valid),
    .i_SPI_tx_data  (tx_data),
    .i_SPI_tx_valid (tx_valid)
  );

  typedef struct {
    logic [9:0] frame;
    int         abort_at;
    logic [7:0] ram;
    int         miso_abort;
    bit         exp_strobe;
    bit         exp_serial;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // abort_at: index of the frame bit whose sampling edge sees ss_n=1 (10 = none).
  // miso_abort / miso_rst: MISO bit index at which ss_n rises / reset fires (8 = none).
  task automatic do_frame(input logic [9:0] f, input int abort_at, input logic [7:0] ram,
                          input int miso_abort, input int miso_rst,
                          input bit exp_strobe, input bit exp_serial);
    bit early;
    bit cut;
    early = 1'b0;
    cut   = 1'b0;
    ss_n  = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      mosi = f[9-i];
      if (i == abort_at) ss_n = 1'b1;
      tick();
      if (i == abort_at) break;
      if (i < 9 && rx_valid) early = 1'b1;
    end
    check("no_early_strobe", int'(early), 0);
    check("strobe", int'(rx_valid), int'(exp_strobe));
    if (exp_strobe) check("rx_data", int'(rx_data), int'(f));
    if (abort_at < 10) check("abort_miso", int'(miso), 0);
    if (exp_serial) begin
      tick();
      check("strobe_one_cycle", int'(rx_valid), 0);
      tx_data  = ram;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        if (j == miso_rst) begin
          rst_n = 1'b0;
          #1;
          check("rst_miso", int'(miso), 0);
          check("rst_rx", int'({rx_valid, rx_data}), 0);
          ss_n = 1'b1;
          #1;
          rst_n = 1'b1;
          cut   = 1'b1;
          break;
        end
        if (j == miso_abort) begin
          ss_n = 1'b1;
          tick();
          check("miso_abort", int'(miso), 0);
          cut = 1'b1;
          break;
        end
        check("miso_bit", int'(miso), int'(ram[7-j]));
        tick();
      end
      if (!cut) check("miso_after_byte", int'(miso), 0);
    end else if (abort_at == 10) begin
      // Held frame: extra bits and stray RAM strobes must be ignored.
      early = 1'b0;
      for (int k = 0; k < 3; k++) begin
        mosi     = 1'($urandom);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        if (rx_valid || miso) early = 1'b1;
      end
      tx_valid = 1'b0;
      check("held_quiet", int'(early), 0);
    end
    ss_n = 1'b1;
    tick();
    tick();
    check("idle_miso", int'(miso), 0);
  endtask

  initial begin
    tbl[0]  = '{10'h0A5, 10, 8'h00, 8, 1'b1, 1'b0};
    tbl[1]  = '{10'h13C, 10, 8'h00, 8, 1'b1, 1'b0};
    tbl[2]  = '{10'h2A5, 10, 8'h00, 8, 1'b1, 1'b0};
    tbl[3]  = '{10'h300, 10, 8'hC3, 8, 1'b1, 1'b1};
    tbl[4]  = '{10'h0FF,  6, 8'h00, 8, 1'b0, 1'b0};
    tbl[5]  = '{10'h1AB, 10, 8'h00, 8, 1'b1, 1'b0};
    tbl[6]  = '{10'h280, 10, 8'h00, 8, 1'b1, 1'b0};
    tbl[7]  = '{10'h3FF, 10, 8'h5A, 3, 1'b1, 1'b1};
    tbl[8]  = '{10'h311, 10, 8'h96, 8, 1'b1, 1'b1};
    tbl[9]  = '{10'h055,  9, 8'h00, 8, 1'b0, 1'b0};
    tbl[10] = '{10'h2C0,  0, 8'h00, 8, 1'b0, 1'b0};
    tbl[11] = '{10'h2C0, 10, 8'h00, 8, 1'b1, 1'b0};
    tbl[12] = '{10'h3C0, 10, 8'h81, 8, 1'b1, 1'b1};

    // Reset held with the slave selected and MOSI toggling.
    ss_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mosi = ~mosi;
      tick();
    end
    check("reset_miso", int'(miso), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    ss_n  = 1'b1;
    rst_n = 1'b1;
    tick();
    tick();

    for (int v = 0; v < 13; v++) begin
      do_frame(tbl[v].frame, tbl[v].abort_at, tbl[v].ram, tbl[v].miso_abort, 8,
               tbl[v].exp_strobe, tbl[v].exp_serial);
    end

    // Async reset during MISO bit 4; the next read op must be treated as a read address.
    do_frame(10'h2A5, 10, 8'h00, 8, 8, 1'b1, 1'b0);
    do_frame(10'h300, 10, 8'hA5, 8, 4, 1'b1, 1'b1);
    do_frame(10'h2F0, 10, 8'h00, 8, 8, 1'b1, 1'b0);
    do_frame(10'h301, 10, 8'h3C, 8, 8, 1'b1, 1'b1);

    model_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [9:0] f;
      logic [7:0] ram;
      int         abort_at;
      int         miso_abort;
      bit         strobe;
      bit         serial;
      f          = 10'($urandom);
      ram        = 8'($urandom);
      abort_at   = ($urandom_range(3) == 0) ? int'($urandom_range(9)) : 10;
      strobe     = (abort_at == 10);
      serial     = strobe && f[9] && model_seen;
      miso_abort = (serial && $urandom_range(3) == 0) ? int'($urandom_range(7)) : 8;
      do_frame(f, abort_at, ram, miso_abort, 8, strobe, serial);
      if (strobe && f[9] && !model_seen) model_seen = 1'b1;
      else if (serial && miso_abort == 8) model_seen = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
